// File: rtl/instr_mem_loader.sv
// instr_mem_loader: packs a UART byte stream MSB-first into words and writes them to instruction RAM.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_load_start begins a load;
//   i_rx_data/i_rx_valid byte stream; o_mem_we/o_mem_addr/o_mem_data RAM write port;
//   o_cpu_rst holds the CPU in reset until loading ends; o_busy/o_done/o_full status;
//   o_word_count words written in the current load.
module instr_mem_loader #(
  parameter int                 NB_BITS   = 32,
  parameter int                 RAM_DEPTH = 10,
  parameter logic [NB_BITS-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_load_start,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  output logic                 o_mem_we,
  output logic [RAM_DEPTH-1:0] o_mem_addr,
  output logic [NB_BITS-1:0]   o_mem_data,
  output logic                 o_cpu_rst,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_full,
  output logic [RAM_DEPTH-2:0] o_word_count
);
  localparam int NB_BYTES = NB_BITS / 8;
  localparam int BCW = $clog2(NB_BYTES) + 1;
  localparam logic [RAM_DEPTH-1:0] LAST_ADDR = {{(RAM_DEPTH-2){1'b1}}, 2'b00};
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t               r_state, w_next;
  logic [BCW-1:0]       r_byte_cnt;
  logic [RAM_DEPTH-1:0] r_addr;
  logic [NB_BITS-9:0]   r_pack;
  logic [NB_BITS-1:0]   w_word;
  logic                 w_take, w_last, w_halt, w_start;
  // r_pack keeps only the bytes already received; the incoming byte completes the word
  assign w_word  = {r_pack, i_rx_data};
  assign w_take  = r_state == LOAD && i_rx_valid;
  assign w_last  = w_take && r_byte_cnt == BCW'(NB_BYTES - 1);
  assign w_halt  = w_word == HALT_WORD;
  assign w_start = r_state != LOAD && i_load_start;
  assign o_busy    = r_state == LOAD;
  assign o_done    = r_state == DONE;
  assign o_cpu_rst = r_state != DONE;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (w_start) w_next = LOAD;
    else if (w_last && (w_halt || r_addr == LAST_ADDR)) w_next = DONE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_data   <= '0;
      o_full       <= 1'b0;
      o_word_count <= '0;
      r_byte_cnt   <= '0;
      r_addr       <= '0;
      r_pack       <= '0;
    end else begin
      o_mem_we <= w_last;
      if (w_start) begin
        o_full       <= 1'b0;
        o_word_count <= '0;
        r_byte_cnt   <= '0;
        r_addr       <= '0;
      end else if (w_take) begin
        r_pack     <= w_word[NB_BITS-9:0];
        r_byte_cnt <= w_last ? '0 : r_byte_cnt + 1'b1;
        if (w_last) begin
          o_mem_data   <= w_word;
          o_mem_addr   <= r_addr;
          r_addr       <= r_addr + RAM_DEPTH'(4);
          o_word_count <= o_word_count + 1'b1;
          o_full       <= !w_halt && r_addr == LAST_ADDR;
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed self-checking bench for instr_mem_loader.
module tb_instr_mem_loader;
  logic        i_clk = 0, i_rst_n = 0, i_load_start = 0, i_rx_valid = 0;
  logic [7:0]  i_rx_data = 0;
  logic        o_mem_we, o_cpu_rst, o_busy, o_done, o_full;
  logic [9:0]  o_mem_addr;
  logic [31:0] o_mem_data;
  logic [8:0]  o_word_count;
  int          n_chk = 0, n_pass = 0;
  logic [9:0]  log_a[$];
  logic [31:0] log_d[$];

  instr_mem_loader dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_load_start(i_load_start),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .o_cpu_rst(o_cpu_rst), .o_busy(o_busy), .o_done(o_done), .o_full(o_full),
    .o_word_count(o_word_count)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    #1;
    if (o_mem_we) begin
      log_a.push_back(o_mem_addr);
      log_d.push_back(o_mem_data);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_data = b;
    i_rx_valid = 1;
    @(negedge i_clk);
    i_rx_valid = 0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send(w[8*k +: 8]);
  endtask

  task automatic pulse_start;
    i_load_start = 1;
    @(negedge i_clk);
    i_load_start = 0;
  endtask

  task automatic restart;
    i_rst_n = 0;
    @(negedge i_clk);
    i_rst_n = 1;
    pulse_start();
    log_a.delete();
    log_d.delete();
  endtask

  initial begin
    int bad;
    repeat (2) @(negedge i_clk);
    chk("rst_we", o_mem_we, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_data", o_mem_data, 0);
    chk("rst_cpu", o_cpu_rst, 1);
    chk("rst_flags", {o_busy, o_done, o_full}, 0);
    chk("rst_wc", o_word_count, 0);
    i_rst_n = 1;
    @(negedge i_clk);
    send(8'h77);
    chk("idle_ignore", log_a.size(), 0);
    pulse_start();
    chk("t1_busy", o_busy, 1);
    send(8'h20); send(8'h01); send(8'h00); send(8'h05);
    chk("t1_we", o_mem_we, 1);
    chk("t1_addr", o_mem_addr, 0);
    chk("t1_data", o_mem_data, 32'h20010005);
    chk("t1_wc", o_word_count, 1);
    chk("t1_cpu", o_cpu_rst, 1);
    @(negedge i_clk);
    chk("t1_we_one", o_mem_we, 0);

    restart();
    send_word(32'h11223344); send_word(32'h55667788); send_word(32'h99AABBCC);
    repeat (2) @(negedge i_clk);
    chk("t2_n", log_a.size(), 3);
    if (log_a.size() == 3) begin
      chk("t2_a0", log_a[0], 0);  chk("t2_d0", log_d[0], 32'h11223344);
      chk("t2_a1", log_a[1], 4);  chk("t2_d1", log_d[1], 32'h55667788);
      chk("t2_a2", log_a[2], 8);  chk("t2_d2", log_d[2], 32'h99AABBCC);
    end
    chk("t2_wc", o_word_count, 3);

    restart();
    send_word(32'h0);
    send_word(32'hFFFFFFFF);
    chk("t3_we", o_mem_we, 1);
    chk("t3_addr", o_mem_addr, 4);
    chk("t3_data", o_mem_data, 32'hFFFFFFFF);
    chk("t3_done", o_done, 1);
    chk("t3_cpu", o_cpu_rst, 0);
    chk("t3_busy", o_busy, 0);
    chk("t3_wc", o_word_count, 2);
    chk("t3_full", o_full, 0);
    send_word(32'h01020304);
    @(negedge i_clk);
    chk("t3_nowr", log_a.size(), 2);

    restart();
    for (int i = 0; i < 256; i++) send_word({16'h1234, 16'(i)});
    @(negedge i_clk);
    chk("t4_n", log_a.size(), 256);
    bad = 0;
    for (int i = 0; i < log_a.size(); i++)
      if (log_a[i] != 10'(4 * i) || log_d[i] != {16'h1234, 16'(i)}) bad++;
    chk("t4_seq", bad, 0);
    chk("t4_last", o_mem_addr, 10'h3FC);
    chk("t4_full", o_full, 1);
    chk("t4_done", o_done, 1);
    chk("t4_wc", o_word_count, 256);
    send_word(32'h0BADF00D);
    @(negedge i_clk);
    chk("t4_nowr", log_a.size(), 256);

    restart();
    send_word(32'hCAFEBABE);
    send(8'hAA); send(8'hBB);
    #2 i_rst_n = 0;
    #1;
    chk("t5_addr", o_mem_addr, 0);
    chk("t5_data", o_mem_data, 0);
    chk("t5_wc", o_word_count, 0);
    chk("t5_st", {o_busy, o_done, o_full, o_cpu_rst, o_mem_we}, 5'b00010);
    @(negedge i_clk);
    i_rst_n = 1;
    pulse_start();
    log_a.delete(); log_d.delete();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("t5_n", log_a.size(), 1);
    chk("t5_addr2", o_mem_addr, 0);
    chk("t5_data2", o_mem_data, 32'h01020304);

    send_word(32'hFFFFFFFF);
    @(negedge i_clk);
    chk("t6_done0", o_done, 1);
    pulse_start();
    chk("t6_done", o_done, 0);
    chk("t6_cpu", o_cpu_rst, 1);
    chk("t6_busy", o_busy, 1);
    send_word(32'h0A0B0C0D);
    chk("t6_we", o_mem_we, 1);
    chk("t6_addr", o_mem_addr, 0);
    chk("t6_data", o_mem_data, 32'h0A0B0C0D);
    chk("t6_wc", o_word_count, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the instruction-memory interface: the debug unit uses it to fill instruction RAM before the fetch stage reads it.
- Takes a byte stream (UART receiver, one byte per i_rx_valid pulse), packs it MSB-first into NB_BITS-wide words and issues single-cycle write strobes at sequential word-aligned byte addresses.
- Holds the CPU pipeline in reset while loading.
- Ends on a HALT word or when memory is full.

Parameters:
- NB_BITS, 32, instruction/data word width; must be a multiple of 8.
- RAM_DEPTH, 10, byte-address width of instruction RAM. Word capacity is 2^(RAM_DEPTH-2).
- HALT_WORD, 32'hFFFFFFFF, terminating instruction; it is written to RAM, then loading ends.

Ports:
- i_clk, input, 1, clock; all logic is on the rising edge.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_load_start, input, 1, single-cycle pulse that begins a load.
- i_rx_data, input, 8, received byte.
- i_rx_valid, input, 1, i_rx_data is valid this cycle; one-cycle pulse per byte.
- o_mem_we, output, 1, instruction RAM write enable; one cycle per word.
- o_mem_addr, output, RAM_DEPTH, byte address of the write; bits [1:0] are always 0.
- o_mem_data, output, NB_BITS, word to write.
- o_cpu_rst, output, 1, high while the CPU must be held in reset.
- o_busy, output, 1, high in the LOAD state.
- o_done, output, 1, load finished; stays high until the next i_load_start.
- o_full, output, 1, memory filled without a HALT word.
- o_word_count, output, RAM_DEPTH-1, number of words written in the current load.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, byte counter 0, address 0.
  - Outputs: o_mem_we=0, o_mem_addr=0, o_mem_data=0, o_cpu_rst=1, o_busy=0, o_done=0, o_full=0, o_word_count=0.
  - Reset asserted mid-load aborts the load immediately; the partial word is discarded.
- States: IDLE, LOAD, DONE.
- IDLE:
  - o_cpu_rst=1.
  - i_load_start -> LOAD; clears address, byte counter, o_word_count, o_full.
  - i_rx_valid is ignored.
- LOAD:
  - o_busy=1, o_cpu_rst=1.
  - Each i_rx_valid byte shifts into the pack register MSB-first: first byte -> bits [NB_BITS-1:NB_BITS-8].
  - On the edge that samples byte NB_BITS/8:
    - o_mem_data is loaded with the full word.
    - o_mem_addr is set to the current address.
    - o_mem_we goes to 1 for exactly the next cycle.
    - Byte counter returns to 0.
  - Address advances by 4 and o_word_count by 1 on the same edge as the write strobe's capture.
  - A byte arriving during the o_mem_we cycle is accepted; there is no dead cycle, so back-to-back bytes every cycle are supported.
  - If the completed word == HALT_WORD: the word is still written; state -> DONE on the same edge.
  - If the written address is the last word (2^RAM_DEPTH-4) and the word is not HALT: o_full=1, state -> DONE.
  - i_load_start while in LOAD is ignored.
- DONE:
  - o_done=1, o_cpu_rst=0 (CPU released). o_busy=0, o_mem_we=0.
  - The o_mem_we asserted for the final word still completes in the first DONE cycle.
  - i_rx_valid is ignored.
  - i_load_start -> LOAD with a full restart: address 0, counters cleared, o_done=0, o_full=0, o_cpu_rst=1 on the next cycle.
- Address wrap: never occurs; o_full terminates the load first.
- Outside write cycles, o_mem_addr and o_mem_data hold their last values.

Test Plan:
- Reset, pulse i_load_start, send bytes 20,01,00,05 -> one cycle of o_mem_we with o_mem_addr=0 and o_mem_data=32'h20010005; o_word_count=1; o_cpu_rst=1.
- Stream 12 bytes on consecutive cycles (3 words, no gaps) -> three single-cycle writes at addresses 0,4,8 with the correct words; no bytes lost.
- Send word 32'h00000000 then FF,FF,FF,FF:
  - Second write is to addr 4 with data FFFFFFFF.
  - o_done=1 and o_cpu_rst=0 in the cycle after the HALT write strobe's capture.
  - o_word_count=2, o_full=0.
  - Extra bytes afterwards cause no writes.
- Send 256 non-HALT words (RAM_DEPTH=10) -> last write is at addr 0x3FC; o_full=1, o_done=1; a 257th word causes no write.
- Drop i_rst_n after 2 bytes of a word -> all outputs return to reset values asynchronously.
  - Restart and send 4 bytes -> word written at addr 0 containing only the new bytes.
- From DONE, pulse i_load_start and send one word -> o_done=0, o_cpu_rst=1, write at addr 0, o_word_count=1.
